registrador_tempo: RTL and testbench

REGISTRADOR_TEMPO -- requirements
Module: registrador_tempo

---
 rtl/registrador_tempo.sv | 152 +++++++++++++++
 tb/tb_registrador_tempo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/registrador_tempo.sv
// Microwave time-entry register: debounced keypad digits shift into an MM:SS BCD display.
// The FSM accepts each key press once, and only after the key has been stable for DEBOUNCE cycles.
module registrador_tempo #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] BCD,
  input  logic       valido,
  input  logic       habilita,
  input  logic       limpa,
  output logic [3:0] min_dez,
  output logic [3:0] min_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] seg_uni,
  output logic [2:0] num_digitos,
  output logic       cheio,
  output logic       digito_ok,
  output logic       tempo_valido
);

  // state        | meaning
  // OCIOSO       | no key seen, waiting for a press
  // FILTRA_PRESS | candidate key latched, counting stable cycles
  // ESPERA_SOLTA | key accepted (or refused), waiting for release
  // FILTRA_SOLTA | release seen, counting stable released cycles
  typedef enum logic [1:0] {OCIOSO, FILTRA_PRESS, ESPERA_SOLTA, FILTRA_SOLTA} estado_t;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic       valido_s1, valido_s2;
  logic [3:0] bcd_s1, bcd_s2;
  logic       tecla_ok;
  estado_t    estado_q, estado_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic       aceita, aceita_ef;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valido_s1 <= 1'b1;
      valido_s2 <= 1'b1;
      bcd_s1    <= 4'd0;
      bcd_s2    <= 4'd0;
    end else begin
      valido_s1 <= valido;
      valido_s2 <= valido_s1;
      bcd_s1    <= BCD;
      bcd_s2    <= bcd_s1;
    end
  end

  // Codes above 9 behave exactly like "no key".
  assign tecla_ok = !valido_s2 && (bcd_s2 <= 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cnt_q    <= 4'd0;
      cand_q   <= 4'd0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    aceita   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (tecla_ok) begin
          estado_d = FILTRA_PRESS;
          cand_d   = bcd_s2;
          cnt_d    = 4'd1;
        end
      end
      FILTRA_PRESS: begin
        if (tecla_ok && (bcd_s2 == cand_q)) begin
          if (cnt_q >= DEB) begin
            aceita   = 1'b1;
            estado_d = ESPERA_SOLTA;
            cnt_d    = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          estado_d = OCIOSO;
          cnt_d    = 4'd0;
        end
      end
      ESPERA_SOLTA: begin
        if (!tecla_ok) begin
          estado_d = FILTRA_SOLTA;
          cnt_d    = 4'd1;
        end
      end
      FILTRA_SOLTA: begin
        if (tecla_ok) begin
          estado_d = ESPERA_SOLTA;
          cnt_d    = 4'd0;
        end else if (cnt_q >= DEB) begin
          estado_d = OCIOSO;
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        estado_d = OCIOSO;
        cnt_d    = 4'd0;
      end
    endcase
  end

  assign aceita_ef = aceita && habilita && !cheio;

  // limpa wins over a simultaneous acceptance: no shift and no pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_dez     <= 4'd0;
      min_uni     <= 4'd0;
      seg_dez     <= 4'd0;
      seg_uni     <= 4'd0;
      num_digitos <= 3'd0;
      digito_ok   <= 1'b0;
    end else if (limpa) begin
      min_dez     <= 4'd0;
      min_uni     <= 4'd0;
      seg_dez     <= 4'd0;
      seg_uni     <= 4'd0;
      num_digitos <= 3'd0;
      digito_ok   <= 1'b0;
    end else if (aceita_ef) begin
      min_dez     <= min_uni;
      min_uni     <= seg_dez;
      seg_dez     <= seg_uni;
      seg_uni     <= cand_q;
      num_digitos <= num_digitos + 3'd1;
      digito_ok   <= 1'b1;
    end else begin
      digito_ok   <= 1'b0;
    end
  end

  assign cheio        = (num_digitos == 3'd4);
  assign tempo_valido = (seg_dez <= 4'd5) && (num_digitos != 3'd0);

endmodule

// File: tb/tb_registrador_tempo.sv
// Bench for registrador_tempo: run-length key model plus decimal time value, checked every cycle,
// with directed press/bounce/hold/clear/reset scenarios pinned by literal expectations.
module tb_registrador_tempo;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       valido = 1'b1;
  logic       habilita = 1'b1;
  logic       limpa = 1'b0;
  logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
  logic [2:0] num_digitos;
  logic       cheio, digito_ok, tempo_valido;

  registrador_tempo #(.DEBOUNCE(DEB)) dut (
    .clk(clk), .reset(rst), .BCD(bcd), .valido(valido), .habilita(habilita), .limpa(limpa),
    .min_dez(min_dez), .min_uni(min_uni), .seg_dez(seg_dez), .seg_uni(seg_uni),
    .num_digitos(num_digitos), .cheio(cheio), .digito_ok(digito_ok), .tempo_valido(tempo_valido)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;

  // Model: sampled key (or -1) seen through a 2-deep delay; a press is accepted after DEB+1
  // consecutive identical samples while armed, re-armed after DEB+1 consecutive idle samples.
  int p0 = -1, p1 = -1, s;
  bit armed = 1;
  int run_len = 0, run_code = 0, rel_len = 0;
  int val = 0, cnt = 0;
  bit m_dok = 0, acc;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p0 = -1; p1 = -1; armed = 1; run_len = 0; rel_len = 0; run_code = 0;
      val = 0; cnt = 0; m_dok = 0;
    end else begin
      s = p1;
      p1 = p0;
      p0 = (!valido && bcd <= 4'd9) ? int'(bcd) : -1;
      acc = 0;
      if (armed) begin
        if (run_len == 0) begin
          if (s >= 0) begin run_code = s; run_len = 1; end
        end else if (s == run_code) begin
          run_len++;
          if (run_len == DEB + 1) begin acc = 1; armed = 0; run_len = 0; rel_len = 0; end
        end else begin
          run_len = 0;
        end
      end else begin
        if (s < 0) begin
          rel_len++;
          if (rel_len == DEB + 1) begin armed = 1; run_len = 0; end
        end else begin
          rel_len = 0;
        end
      end
      m_dok = 0;
      if (limpa) begin
        val = 0; cnt = 0;
      end else if (acc && habilita && cnt < 4) begin
        val = (val * 10 + run_code) % 10000;
        cnt++;
        m_dok = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [19:0] got, exp;
    got = {min_dez, min_uni, seg_dez, seg_uni, num_digitos, cheio, digito_ok, tempo_valido};
    exp = {4'(val / 1000), 4'((val / 100) % 10), 4'((val / 10) % 10), 4'(val % 10), 3'(cnt),
           cnt == 4, m_dok, ((val / 10) % 10) <= 5 && cnt != 0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_cycle%0d got=%h expected=%h", cyc, got, exp);
    end
    if (digito_ok === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    bcd = code; valido = 1'b0;
    repeat (hold) step();
    valido = 1'b1;
    repeat (rel) step();
  endtask

  function automatic int mmss();
    return min_dez * 1000 + min_uni * 100 + seg_dez * 10 + seg_uni;
  endfunction

  initial begin
    int pc, t0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_time", mmss(), 0);
    chk("reset_num", num_digitos, 0);
    chk("reset_cheio", cheio, 0);
    chk("reset_tv", tempo_valido, 0);
    chk("reset_dok", digito_ok, 0);

    pc = pulse_cnt;
    press(4'd1, 10, 10); press(4'd2, 10, 10); press(4'd3, 10, 10); press(4'd0, 10, 10);
    chk("four_time", mmss(), 1230);
    chk("four_num", num_digitos, 4);
    chk("four_cheio", cheio, 1);
    chk("four_tv", tempo_valido, 1);
    chk("four_pulses", pulse_cnt - pc, 4);

    pc = pulse_cnt;
    press(4'd7, 10, 10);
    chk("fifth_time", mmss(), 1230);
    chk("fifth_pulses", pulse_cnt - pc, 0);
    limpa = 1'b1; step(); limpa = 1'b0; step();
    chk("clear_time", mmss(), 0);
    chk("clear_num", num_digitos, 0);
    chk("clear_cheio", cheio, 0);
    chk("clear_tv", tempo_valido, 0);

    pc = pulse_cnt;
    bcd = 4'd5;
    for (int i = 0; i < 12; i++) begin
      valido = ((i / 2) % 2) != 0;
      step();
    end
    valido = 1'b0; t0 = cyc;
    repeat (10) step();
    valido = 1'b1;
    repeat (10) step();
    chk("bounce_pulses", pulse_cnt - pc, 1);
    chk("bounce_latency", last_pulse_cyc - t0, 7);
    chk("bounce_seg_uni", seg_uni, 5);

    pc = pulse_cnt;
    press(4'd8, 100, 10);
    chk("held_pulses", pulse_cnt - pc, 1);

    pc = pulse_cnt;
    bcd = 4'd8; valido = 1'b0;
    repeat (3) step();
    bcd = 4'd3;
    repeat (10) step();
    valido = 1'b1;
    repeat (10) step();
    chk("change_pulses", pulse_cnt - pc, 1);
    chk("change_time", mmss(), 583);
    chk("change_num", num_digitos, 3);
    chk("change_tv", tempo_valido, 0);

    habilita = 1'b0; pc = pulse_cnt;
    press(4'd9, 10, 10);
    habilita = 1'b1;
    chk("disabled_pulses", pulse_cnt - pc, 0);
    chk("disabled_time", mmss(), 583);

    pc = pulse_cnt;
    bcd = 4'd2; valido = 1'b0;
    repeat (6) step();
    limpa = 1'b1; step(); limpa = 1'b0;
    repeat (4) step();
    valido = 1'b1;
    repeat (10) step();
    chk("limpa_acc_pulses", pulse_cnt - pc, 0);
    chk("limpa_acc_num", num_digitos, 0);
    chk("limpa_acc_time", mmss(), 0);

    pc = pulse_cnt;
    press(4'd12, 10, 10);
    chk("illegal_pulses", pulse_cnt - pc, 0);
    chk("illegal_num", num_digitos, 0);

    press(4'd6, 10, 10);
    chk("pre_reset_num", num_digitos, 1);
    bcd = 4'd4; valido = 1'b0;
    repeat (4) step();
    rst = 1'b1; #1;
    chk("async_reset_num", num_digitos, 0);
    chk("async_reset_time", mmss(), 0);
    step(); step();
    rst = 1'b0; t0 = cyc; pc = pulse_cnt;
    repeat (10) step();
    valido = 1'b1;
    repeat (10) step();
    chk("post_reset_pulses", pulse_cnt - pc, 1);
    chk("post_reset_latency", last_pulse_cyc - t0, 7);
    chk("post_reset_time", mmss(), 4);
    chk("post_reset_num", num_digitos, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached cycle=%0d limit=20000", cyc);
    $fatal(1, "timeout");
  end

endmodule
